// File: rtl/a_burst_collect_pkg.sv
// Shared types and default widths for the burst-collect block.
package a_burst_collect_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefLenW  = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StAbort   = 2'd2
  } state_e;

endpackage

// File: rtl/a_burst_collect_addr_gen.sv
// Burst address generator: latches base/length, counts received words, forms base + count.
module a_burst_collect_addr_gen #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LEN_W-1:0]  cnt_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      len_q  <= len_i;
      cnt_q  <= '0;
    end else if (inc_i && (cnt_q != len_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Offset wraps modulo 2^ADDR_W
  assign addr_o = base_q + ADDR_W'(cnt_q);
  assign cnt_o  = cnt_q;
  assign last_o = ((cnt_q + 1'b1) == len_q);

endmodule

// File: rtl/a_burst_collect.sv
// Burst-write collector: accepts a command, writes N data words to consecutive addresses.
module a_burst_collect
  import a_burst_collect_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              dat_valid_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              timeout_i,
  output logic              tmo_start_o,
  output logic              tmo_stop_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_dat_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  rcv_cnt_o,
  input  logic              err_clr_i
);

  state_e state_q, state_d;

  logic              accept, len_zero, word_acc, cnt_last, last_word;
  logic [ADDR_W-1:0] wr_addr;

  logic              cmd_ready_q, cmd_ready_d;
  logic              tmo_start_q, tmo_start_d;
  logic              tmo_stop_q, tmo_stop_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dat_q, mem_dat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Ready is registered so it reads 0 during reset and 1 whenever the FSM sits in IDLE
  assign accept    = (state_q == StIdle) && cmd_valid_i && cmd_ready_q;
  assign len_zero  = (cmd_len_i == '0);
  assign word_acc  = (state_q == StCollect) && dat_valid_i;
  assign last_word = word_acc && cnt_last;

  a_burst_collect_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk_i (clk_ref),
    .rst_ni(rst_n),
    .load_i(accept),
    .base_i(cmd_addr_i),
    .len_i (cmd_len_i),
    .inc_i (word_acc),
    .addr_o(wr_addr),
    .cnt_o (rcv_cnt_o),
    .last_o(cnt_last)
  );

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Last word beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = len_zero ? StAbort : StCollect;
      StCollect: begin
        if (last_word) begin
          state_d = StIdle;
        end else if (timeout_i) begin
          state_d = StAbort;
        end
      end
      StAbort:   if (err_clr_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == StIdle);
    tmo_start_d = accept && !len_zero;
    tmo_stop_d  = last_word;
    done_d      = last_word;
    mem_we_d    = word_acc;
    mem_addr_d  = word_acc ? wr_addr : mem_addr_q;
    mem_dat_d   = word_acc ? dat_i : mem_dat_q;
    err_d       = err_q;
    if (accept && len_zero) begin
      err_d = 1'b1;
    end else if ((state_q == StCollect) && timeout_i && !last_word) begin
      err_d = 1'b1;
    end else if ((state_q == StAbort) && err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b0;
      tmo_start_q <= 1'b0;
      tmo_stop_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_dat_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      tmo_start_q <= tmo_start_d;
      tmo_stop_q  <= tmo_stop_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_dat_q   <= mem_dat_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign tmo_start_o = tmo_start_q;
  assign tmo_stop_o  = tmo_stop_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_dat_o   = mem_dat_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_a_burst_collect.sv
// Directed bench for a_burst_collect: cycle table plus hand-written corner sequences.
module tb_a_burst_collect;

  logic        clk_ref = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [15:0] cmd_addr_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic        dat_valid_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic        timeout_i = 1'b0;
  logic        tmo_start_o, tmo_stop_o, mem_we_o, done_o, err_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_dat_o;
  logic [15:0] rcv_cnt_o;
  logic        err_clr_i = 1'b0;

  a_burst_collect dut (
    .clk_ref    (clk_ref),
    .rst_n      (rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i (cmd_addr_i),
    .cmd_len_i  (cmd_len_i),
    .dat_valid_i(dat_valid_i),
    .dat_i      (dat_i),
    .timeout_i  (timeout_i),
    .tmo_start_o(tmo_start_o),
    .tmo_stop_o (tmo_stop_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_dat_o  (mem_dat_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rcv_cnt_o  (rcv_cnt_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    logic        cv;
    logic [15:0] ca;
    logic [15:0] cl;
    logic        dv;
    logic [31:0] d;
    logic        tmo;
    logic        clr;
    logic        rdy;
    logic        st;
    logic        sp;
    logic        we;
    logic [15:0] wa;
    logic [31:0] wd;
    logic        dn;
    logic        er;
    logic [15:0] cnt;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_start, n_stop, n_done, n_overlap;
  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];

  function automatic vec_t mkv(input logic cv, input logic [15:0] ca, input logic [15:0] cl,
                               input logic dv, input logic [31:0] d, input logic tmo,
                               input logic clr, input logic rdy, input logic st, input logic sp,
                               input logic we, input logic [15:0] wa, input logic [31:0] wd,
                               input logic dn, input logic er, input logic [15:0] cnt);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cl = cl; v.dv = dv; v.d = d; v.tmo = tmo; v.clr = clr;
    v.rdy = rdy; v.st = st; v.sp = sp; v.we = we; v.wa = wa; v.wd = wd;
    v.dn = dn; v.er = er; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge and logged into the monitor
  task automatic tick();
    @(posedge clk_ref);
    #1;
    if (mem_we_o) begin
      wa_q.push_back(mem_addr_o);
      wd_q.push_back(mem_dat_o);
    end
    n_start += int'(tmo_start_o);
    n_stop  += int'(tmo_stop_o);
    n_done  += int'(done_o);
    if (tmo_start_o && tmo_stop_o) n_overlap++;
  endtask

  task automatic clr_mon();
    wa_q.delete();
    wd_q.delete();
    n_start = 0;
    n_stop  = 0;
    n_done  = 0;
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] l);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    dat_valid_i = 1'b1;
    dat_i       = d;
    tick();
    dat_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rdy"}, 32'(cmd_ready_o), 32'h0);
    chk({tag, ".start"}, 32'(tmo_start_o), 32'h0);
    chk({tag, ".stop"}, 32'(tmo_stop_o), 32'h0);
    chk({tag, ".we"}, 32'(mem_we_o), 32'h0);
    chk({tag, ".addr"}, 32'(mem_addr_o), 32'h0);
    chk({tag, ".dat"}, mem_dat_o, 32'h0);
    chk({tag, ".done"}, 32'(done_o), 32'h0);
    chk({tag, ".err"}, 32'(err_o), 32'h0);
    chk({tag, ".cnt"}, 32'(rcv_cnt_o), 32'h0);
  endtask

  initial begin
    n_overlap = 0;
    clr_mon();

    // Nominal burst: base 0x0100, len 4
    vecs.push_back(mkv(1, 16'h0100, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkv(0, 0, 0, 1, 32'hA000_0000 + k, 0, 0, 0, 0, 0, 1,
                         16'h0100 + 16'(k), 32'hA000_0000 + k, 0, 0, 16'(k + 1)));
    vecs.push_back(mkv(0, 0, 0, 1, 32'hA000_0003, 0, 0, 1, 0, 1, 1, 16'h0103, 32'hA000_0003,
                       1, 0, 4));
    vecs.push_back(mkv(0, 0, 0, 1, 32'hA000_0004, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
    // Timeout after 5 of 8 words
    vecs.push_back(mkv(1, 16'h0200, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mkv(0, 0, 0, 1, 32'hB000_0000 + k, 0, 0, 0, 0, 0, 1,
                         16'h0200 + 16'(k), 32'hB000_0000 + k, 0, 0, 16'(k + 1)));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mkv(0, 0, 0, 1, 32'hC000_0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5));
    // Illegal length
    vecs.push_back(mkv(1, 16'h0300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 32'hD000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset.rdy", 32'(cmd_ready_o), 32'h1);

    foreach (vecs[i]) begin
      cmd_valid_i = vecs[i].cv;
      cmd_addr_i  = vecs[i].ca;
      cmd_len_i   = vecs[i].cl;
      dat_valid_i = vecs[i].dv;
      dat_i       = vecs[i].d;
      timeout_i   = vecs[i].tmo;
      err_clr_i   = vecs[i].clr;
      tick();
      chk($sformatf("v%0d.rdy", i), 32'(cmd_ready_o), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.start", i), 32'(tmo_start_o), 32'(vecs[i].st));
      chk($sformatf("v%0d.stop", i), 32'(tmo_stop_o), 32'(vecs[i].sp));
      chk($sformatf("v%0d.we", i), 32'(mem_we_o), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d.addr", i), 32'(mem_addr_o), 32'(vecs[i].wa));
        chk($sformatf("v%0d.dat", i), mem_dat_o, vecs[i].wd);
      end
      chk($sformatf("v%0d.done", i), 32'(done_o), 32'(vecs[i].dn));
      chk($sformatf("v%0d.err", i), 32'(err_o), 32'(vecs[i].er));
      chk($sformatf("v%0d.cnt", i), 32'(rcv_cnt_o), 32'(vecs[i].cnt));
    end
    cmd_valid_i = 1'b0;
    dat_valid_i = 1'b0;
    timeout_i   = 1'b0;
    err_clr_i   = 1'b0;

    // Gapped data: len 3, five idle cycles before each word
    clr_mon();
    send_cmd(16'h0010, 16'd3);
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick();
      send_word(32'hE000_0000 + k);
    end
    repeat (2) tick();
    chk("gap.nwrites", 32'(wa_q.size()), 32'd3);
    for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
      chk($sformatf("gap.addr%0d", k), 32'(wa_q[k]), 32'h0010 + k);
      chk($sformatf("gap.dat%0d", k), wd_q[k], 32'hE000_0000 + k);
    end
    chk("gap.ndone", 32'(n_done), 32'd1);
    chk("gap.nstart", 32'(n_start), 32'd1);
    chk("gap.nstop", 32'(n_stop), 32'd1);
    chk("gap.err", 32'(err_o), 32'h0);
    chk("gap.cnt", 32'(rcv_cnt_o), 32'd3);

    // Race: last word and timeout in the same cycle
    clr_mon();
    send_cmd(16'h0400, 16'd8);
    for (int k = 0; k < 7; k++) send_word(32'hF000_0000 + k);
    timeout_i = 1'b1;
    send_word(32'hF000_0007);
    chk("race.we", 32'(mem_we_o), 32'h1);
    chk("race.addr", 32'(mem_addr_o), 32'h0407);
    chk("race.done", 32'(done_o), 32'h1);
    chk("race.stop", 32'(tmo_stop_o), 32'h1);
    chk("race.err", 32'(err_o), 32'h0);
    chk("race.cnt", 32'(rcv_cnt_o), 32'd8);
    tick();
    chk("race.err_after", 32'(err_o), 32'h0);
    chk("race.rdy_after", 32'(cmd_ready_o), 32'h1);
    timeout_i = 1'b0;

    // Reset mid-burst, then a wrapping burst
    send_cmd(16'h0500, 16'd6);
    send_word(32'h1111_0000);
    send_word(32'h1111_0001);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    chk("midrst.rdy_after", 32'(cmd_ready_o), 32'h1);
    clr_mon();
    send_cmd(16'hFFFE, 16'd3);
    for (int k = 0; k < 3; k++) send_word(32'h2222_0000 + k);
    tick();
    chk("wrap.nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      chk("wrap.addr0", 32'(wa_q[0]), 32'hFFFE);
      chk("wrap.addr1", 32'(wa_q[1]), 32'hFFFF);
      chk("wrap.addr2", 32'(wa_q[2]), 32'h0000);
    end
    chk("wrap.ndone", 32'(n_done), 32'd1);
    chk("wrap.cnt", 32'(rcv_cnt_o), 32'd3);
    chk("wrap.err", 32'(err_o), 32'h0);
    chk("start_stop_overlap", 32'(n_overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
